// File: rtl/inst_mem_unit.sv
// Instruction memory with a one-cycle registered fetch read and a little-endian byte-stream program loader.
// Optional feature macro: IMEM_PARITY_EN adds one even-parity bit per word, checked on every fetch.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ILEN
`define ILEN 32
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif
`ifndef INVALID_PC
`define INVALID_PC 32'hFFFF_FFFF
`endif
`ifndef INIT_PC
`define INIT_PC 32'h8000_0000
`endif

module inst_mem_unit #(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [`XLEN-1:0]  BASE_ADDR   = `INIT_PC
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [`XLEN-1:0]               i_pc,
  output logic [`ILEN-1:0]               o_inst,
  output logic [`XLEN-1:0]               o_addr,
  output logic                           o_fault,
  output logic                           o_busy,
  input  logic                           i_ld_en,
  input  logic                           i_ld_valid,
  input  logic [7:0]                     i_ld_byte,
  output logic                           o_ld_ready,
  output logic                           o_ld_full,
  output logic [$clog2(DEPTH_WORDS):0]   o_ld_words
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;
  localparam int XW = `XLEN;
  localparam logic [XW-1:0] SPAN      = XW'(4 * DEPTH_WORDS);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH_WORDS);

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [CW-1:0]     words_q, words_d;
  logic              full_q, full_d;
  logic              busy_q, busy_d;
  logic [`ILEN-1:0]  inst_q, inst_d;
  logic [XW-1:0]     addr_q, addr_d;
  logic              fault_q, fault_d;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [31:0]       wdata;
  logic              accept;
  logic [XW-1:0]     off;
  logic [AW-1:0]     ridx;

  logic [31:0]       mem_q [DEPTH_WORDS];
`ifdef IMEM_PARITY_EN
  logic              par_q [DEPTH_WORDS];
`endif

  assign accept = (state_q == LOAD) & ~full_q & i_ld_valid;
  assign off    = i_pc - BASE_ADDR;
  assign ridx   = off[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    words_d = words_q;
    we      = 1'b0;
    waddr   = words_q[AW-1:0];
    wdata   = {8'h00, asm_q};
    case (state_q)
      RUN: begin
        if (i_ld_en) begin
          state_d = LOAD;
          cnt_d   = 2'd0;
          asm_d   = '0;
          words_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          case (cnt_q)
            2'd0: asm_d[7:0]   = i_ld_byte;
            2'd1: asm_d[15:8]  = i_ld_byte;
            2'd2: asm_d[23:16] = i_ld_byte;
            default: begin
              we      = 1'b1;
              wdata   = {i_ld_byte, asm_q};
              words_d = words_q + CW'(1);
              asm_d   = '0;
            end
          endcase
          cnt_d = cnt_q + 2'd1;
        end
        // A byte accepted on the same edge as the enable drop still decides FLUSH vs RUN.
        if (!i_ld_en) state_d = (cnt_d != 2'd0) ? FLUSH : RUN;
      end
      FLUSH: begin
        we      = 1'b1;
        words_d = words_q + CW'(1);
        cnt_d   = 2'd0;
        asm_d   = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    full_d = (words_d == DEPTH_CNT);
    busy_d = (state_d != RUN);
  end

  always_comb begin
    inst_d  = `NOP;
    addr_d  = `INVALID_PC;
    fault_d = 1'b0;
    if (state_q == RUN && !i_ld_en) begin
      addr_d = i_pc;
      if (i_pc[1:0] != 2'b00 || off >= SPAN) begin
        fault_d = 1'b1;
      end else begin
        inst_d = mem_q[ridx];
`ifdef IMEM_PARITY_EN
        if ((^mem_q[ridx]) != par_q[ridx]) begin
          inst_d  = `NOP;
          fault_d = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      asm_q   <= '0;
      words_q <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      inst_q  <= `NOP;
      addr_q  <= `INVALID_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      words_q <= words_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

  // Array contents survive rstn so a program loaded before reset is still fetchable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
`ifdef IMEM_PARITY_EN
      par_q[waddr] <= ^wdata;
`endif
    end
  end

  assign o_inst     = inst_q;
  assign o_addr     = addr_q;
  assign o_fault    = fault_q;
  assign o_busy     = busy_q;
  assign o_ld_ready = (state_q == LOAD) & ~full_q;
  assign o_ld_full  = full_q;
  assign o_ld_words = words_q;

endmodule

// File: tb/tb_inst_mem_unit.sv
// Scoreboard bench for inst_mem_unit: loader sequences, fetch reads, fault boundaries, full and reset cases.
module tb_inst_mem_unit;

  localparam int          D    = 1024;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] INV  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] i_pc;
  logic [31:0] o_inst;
  logic [31:0] o_addr;
  logic        o_fault;
  logic        o_busy;
  logic        i_ld_en;
  logic        i_ld_valid;
  logic [7:0]  i_ld_byte;
  logic        o_ld_ready;
  logic        o_ld_full;
  logic [10:0] o_ld_words;

  inst_mem_unit #(.DEPTH_WORDS(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn), .i_pc(i_pc), .o_inst(o_inst), .o_addr(o_addr),
    .o_fault(o_fault), .o_busy(o_busy), .i_ld_en(i_ld_en), .i_ld_valid(i_ld_valid),
    .i_ld_byte(i_ld_byte), .o_ld_ready(o_ld_ready), .o_ld_full(o_ld_full),
    .o_ld_words(o_ld_words)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        fault;
  } rsp_t;

  rsp_t sbq[$];
  logic rd_issue = 1'b0;
  logic rsp_vld  = 1'b0;

  always @(posedge clk) rsp_vld <= rd_issue;

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rsp_vld) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=response required=none");
      end else begin
        e = sbq.pop_front();
        chk("rd_inst", o_inst, e.inst);
        chk("rd_addr", o_addr, e.addr);
        chk("rd_fault", {31'b0, o_fault}, {31'b0, e.fault});
      end
    end
  end

  task automatic rd(input logic [31:0] pc, input logic [31:0] ei, input logic ef);
    rsp_t e;
    e.inst  = ei;
    e.addr  = pc;
    e.fault = ef;
    i_pc     = pc;
    rd_issue = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_ld_valid = 1'b1;
    i_ld_byte  = b;
    while (!o_ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL ld_ready_timeout actual=0 required=1");
    end
    @(negedge clk);
    i_ld_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inst"},  o_inst, NOP);
    chk({tag, "_addr"},  o_addr, INV);
    chk({tag, "_fault"}, {31'b0, o_fault}, 32'd0);
    chk({tag, "_busy"},  {31'b0, o_busy}, 32'd0);
    chk({tag, "_ready"}, {31'b0, o_ld_ready}, 32'd0);
    chk({tag, "_full"},  {31'b0, o_ld_full}, 32'd0);
    chk({tag, "_words"}, 32'(o_ld_words), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn       = 1'b0;
    i_pc       = BASE;
    i_ld_en    = 1'b0;
    i_ld_valid = 1'b0;
    i_ld_byte  = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rstn = 1'b1;
    @(negedge clk);

    // T1: two full words
    i_ld_en = 1'b1;
    @(negedge clk);
    chk("t1_busy", {31'b0, o_busy}, 32'd1);
    chk("t1_ready", {31'b0, o_ld_ready}, 32'd1);
    chk("t1_addr_inv", o_addr, INV);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    chk("t1_words", 32'(o_ld_words), 32'd2);
    i_ld_en = 1'b0;
    @(negedge clk);
    chk("t1_busy_off", {31'b0, o_busy}, 32'd0);

    // T2: reads, including a held PC
    rd(BASE,     32'h0000_0013, 1'b0);
    rd(BASE + 4, 32'h0010_0093, 1'b0);
    rd(BASE + 4, 32'h0010_0093, 1'b0);

    // T3: fault boundaries
    rd(BASE + 2,     NOP, 1'b1);
    rd(BASE + 4 * D, NOP, 1'b1);
    rd(BASE - 4,     NOP, 1'b1);

    // T4: partial word flush
    i_ld_en = 1'b1;
    @(negedge clk);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    i_ld_en = 1'b0;
    @(negedge clk);
    chk("t4_flush_busy", {31'b0, o_busy}, 32'd1);
    chk("t4_flush_words", 32'(o_ld_words), 32'd0);
    @(negedge clk);
    chk("t4_run_busy", {31'b0, o_busy}, 32'd0);
    chk("t4_words", 32'(o_ld_words), 32'd1);
    rd(BASE,     32'h00CC_BBAA, 1'b0);
    rd(BASE + 4, 32'h0010_0093, 1'b0);

    // T5: fill the whole array, then offer three extra bytes
    i_ld_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4 * D; i++) send_byte(i[7:0]);
    chk("t5_full", {31'b0, o_ld_full}, 32'd1);
    chk("t5_ready", {31'b0, o_ld_ready}, 32'd0);
    chk("t5_words", 32'(o_ld_words), D);
    i_ld_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_ld_byte = 8'hE0 + 8'(k);
      @(negedge clk);
      chk("t5_extra_ready", {31'b0, o_ld_ready}, 32'd0);
    end
    i_ld_valid = 1'b0;
    chk("t5_words_hold", 32'(o_ld_words), D);
    i_ld_en = 1'b0;
    @(negedge clk);
    chk("t5_busy_off", {31'b0, o_busy}, 32'd0);
    rd(BASE + 20,          32'h1716_1514, 1'b0);
    rd(BASE + 4 * (D - 1), 32'hFFFE_FDFC, 1'b0);

    // T6: reset in the middle of word 2
    i_ld_en = 1'b1;
    @(negedge clk);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    rstn    = 1'b0;
    i_ld_en = 1'b0;
    #1;
    chk_reset_outputs("t6");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rd(BASE,     32'h0000_0013, 1'b0);
    rd(BASE + 4, 32'h0010_0093, 1'b0);
    rd(BASE + 8, 32'h0B0A_0908, 1'b0);
`ifdef IMEM_PARITY_EN
    dut.par_q[0] = ~dut.par_q[0];
    rd(BASE, NOP, 1'b1);
`endif

    @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
